// File: rtl/flit_link_arbiter.sv
// Packet-atomic round-robin arbiter: shares one NoC link among NUM_PORTS sources,
// holding the grant from HEAD to TAIL, with a one-entry registered output stage.
module flit_link_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic                            proto_err
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t                 r_state;
  logic [NUM_PORTS-1:0]   r_grant;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_first;
  logic                   r_out_valid;
  logic [FLIT_WIDTH-1:0]  r_out_flit;
  logic                   r_proto_err;

  logic [NUM_PORTS-1:0]   w_elig;
  logic [NUM_PORTS-1:0]   w_pick;
  logic                   w_found;
  logic [FLIT_WIDTH-1:0]  w_sel_flit;
  logic [PTR_W-1:0]       w_gidx;
  logic [PTR_W-1:0]       w_next_ptr;
  logic                   w_can_load;
  logic                   w_xfer;
  logic                   w_sel_head;
  logic                   w_sel_tail;

  // Type bit 0 marks a packet start (HEAD/SINGLE), bit 1 a packet end (TAIL/SINGLE).
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_elig[i] = in_valid[i] & in_flit[i*FLIT_WIDTH + FLIT_DATA_WIDTH];
    end
  end

  // Two passes: ports at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_elig[i] && (PTR_W'(i) >= r_rr_ptr)) begin
        w_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_elig[i] && (PTR_W'(i) < r_rr_ptr)) begin
        w_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_flit = '0;
    w_gidx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) begin
        w_sel_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        w_gidx     = PTR_W'(i);
      end
    end
  end

  assign w_next_ptr = (w_gidx == PTR_W'(NUM_PORTS-1)) ? '0 : w_gidx + PTR_W'(1);
  assign w_can_load = !r_out_valid || out_ready;
  assign in_ready   = ((r_state == S_LOCKED) && w_can_load) ? r_grant : '0;
  assign w_xfer     = |(in_valid & in_ready);
  assign w_sel_head = w_sel_flit[FLIT_DATA_WIDTH];
  assign w_sel_tail = w_sel_flit[FLIT_DATA_WIDTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_flit  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_first <= 1'b1;
            r_state <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (w_xfer) begin
            r_first <= 1'b0;
            if ((w_sel_head && !r_first) || (!w_sel_head && r_first)) begin
              r_proto_err <= 1'b1;
            end
            if (w_sel_tail) begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Load and drain may coincide, which keeps the link at one flit per cycle.
      if (w_xfer) begin
        r_out_flit  <= w_sel_flit;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_flit  = r_out_flit;
  assign grant     = r_grant;
  assign busy      = (r_state == S_LOCKED);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_flit_link_arbiter.sv
// Directed bench for flit_link_arbiter: a per-cycle vector table plus
// source/sink sequences for fairness, atomicity, backpressure, errors and reset.
module tb_flit_link_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int FW = DW + TW;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid;
  logic [NP*FW-1:0]  in_flit;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic [FW-1:0]     out_flit;
  logic              out_ready;
  logic [NP-1:0]     grant;
  logic              busy;
  logic              proto_err;

  flit_link_arbiter #(
    .NUM_PORTS(NP), .FLIT_DATA_WIDTH(DW), .FLIT_TYPE_WIDTH(TW), .FLIT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .grant(grant), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [FW-1:0] src_q [NP][$];
  logic [FW-1:0] sink [$];
  logic [NP-1:0] last_xfer;

  typedef struct {
    logic [NP-1:0]    vld;
    logic [NP*FW-1:0] flits;
    logic             ordy;
    logic [NP-1:0]    e_grant;
    logic             e_busy;
    logic             e_ovld;
    logic [FW-1:0]    e_oflit;
    logic [NP-1:0]    e_irdy;
    logic             e_perr;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [FW-1:0] mkf(input logic [1:0] t, input logic [DW-1:0] d);
    return {t, d};
  endfunction

  function automatic logic [NP*FW-1:0] pack4(input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                                             input logic [FW-1:0] f2, input logic [FW-1:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  function automatic vec_t mkv(input logic [NP-1:0] vld, input logic [NP*FW-1:0] flits,
                               input logic [NP-1:0] eg, input logic eb, input logic eov,
                               input logic [FW-1:0] eof, input logic [NP-1:0] eir,
                               input logic ep);
    vec_t v;
    v.vld = vld; v.flits = flits; v.ordy = 1'b1;
    v.e_grant = eg; v.e_busy = eb; v.e_ovld = eov; v.e_oflit = eof;
    v.e_irdy = eir; v.e_perr = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_flit = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    sink.delete();
    last_xfer = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle of queue-driven sources and an accepting-or-stalling sink.
  task automatic step(input logic ordy);
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (last_xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_flit[i*FW +: FW] = src_q[i][0];
      end else begin
        in_valid[i] = 1'b0;
      end
    end
    out_ready = ordy;
    #1;
    last_xfer = in_valid & in_ready;
    if (out_valid && out_ready) sink.push_back(out_flit);
  endtask

  logic [NP-1:0] fair_exp [9];
  logic [FW-1:0] exp_f [$];
  logic          early;
  int            k;

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_flit = '0;
    out_ready = 1'b1;
    last_xfer = '0;

    // Table: single packet on port 2, pointer wrap, non-head ignored in IDLE.
    vecs.push_back(mkv(4'b0100, pack4('0, '0, mkf(T_HEAD, 1), '0), 4'b0000, 0, 0, '0, 4'b0000, 0));
    vecs.push_back(mkv(4'b0100, pack4('0, '0, mkf(T_HEAD, 1), '0), 4'b0100, 1, 0, '0, 4'b0100, 0));
    vecs.push_back(mkv(4'b0100, pack4('0, '0, mkf(T_BODY, 2), '0), 4'b0100, 1, 1, mkf(T_HEAD, 1), 4'b0100, 0));
    vecs.push_back(mkv(4'b0100, pack4('0, '0, mkf(T_TAIL, 3), '0), 4'b0100, 1, 1, mkf(T_BODY, 2), 4'b0100, 0));
    vecs.push_back(mkv(4'b0000, '0, 4'b0000, 0, 1, mkf(T_TAIL, 3), 4'b0000, 0));
    vecs.push_back(mkv(4'b1001, pack4(mkf(T_SGL, 'hA0), '0, '0, mkf(T_SGL, 'hA3)),
                       4'b0000, 0, 0, mkf(T_TAIL, 3), 4'b0000, 0));
    vecs.push_back(mkv(4'b1001, pack4(mkf(T_SGL, 'hA0), '0, '0, mkf(T_SGL, 'hA3)),
                       4'b1000, 1, 0, mkf(T_TAIL, 3), 4'b1000, 0));
    vecs.push_back(mkv(4'b0001, pack4(mkf(T_SGL, 'hA0), '0, '0, '0),
                       4'b0000, 0, 1, mkf(T_SGL, 'hA3), 4'b0000, 0));
    vecs.push_back(mkv(4'b0001, pack4(mkf(T_SGL, 'hA0), '0, '0, '0),
                       4'b0001, 1, 0, mkf(T_SGL, 'hA3), 4'b0001, 0));
    vecs.push_back(mkv(4'b0000, '0, 4'b0000, 0, 1, mkf(T_SGL, 'hA0), 4'b0000, 0));
    vecs.push_back(mkv(4'b0010, pack4('0, mkf(T_BODY, 5), '0, '0),
                       4'b0000, 0, 0, mkf(T_SGL, 'hA0), 4'b0000, 0));
    vecs.push_back(mkv(4'b0010, pack4('0, mkf(T_BODY, 5), '0, '0),
                       4'b0000, 0, 0, mkf(T_SGL, 'hA0), 4'b0000, 0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      in_valid = vecs[i].vld;
      in_flit = vecs[i].flits;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("row%0d_grant", i), 64'(grant), 64'(vecs[i].e_grant));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ovld));
      chk($sformatf("row%0d_out_flit", i), 64'(out_flit), 64'(vecs[i].e_oflit));
      chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
      chk($sformatf("row%0d_proto_err", i), 64'(proto_err), 64'(vecs[i].e_perr));
    end

    // Fairness: every port keeps offering SINGLE flits.
    fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < 3; j++) src_q[i].push_back(mkf(T_SGL, DW'(16*i + j)));
    end
    step(1'b1);
    for (int c = 0; c < 9; c++) begin
      step(1'b1);
      chk($sformatf("fair_grant_c%0d", c), 64'(grant), 64'(fair_exp[c]));
    end

    // Atomicity: port 1 must wait for the whole port-0 packet.
    do_reset();
    src_q[0] = '{mkf(T_HEAD, 'h100), mkf(T_BODY, 'h101), mkf(T_BODY, 'h102), mkf(T_TAIL, 'h103)};
    src_q[1] = '{mkf(T_SGL, 'h200)};
    exp_f = '{mkf(T_HEAD, 'h100), mkf(T_BODY, 'h101), mkf(T_BODY, 'h102), mkf(T_TAIL, 'h103),
              mkf(T_SGL, 'h200)};
    early = 1'b0;
    k = 0;
    while (sink.size() < 5 && k < 30) begin
      step(1'b1);
      if (grant[1] && src_q[0].size() > 0) early = 1'b1;
      k++;
    end
    chk("atomic_early_grant", 64'(early), 64'(0));
    chk("atomic_sink_count", 64'(sink.size()), 64'(5));
    for (int j = 0; j < 5; j++) begin
      if (j < sink.size()) chk($sformatf("atomic_flit%0d", j), 64'(sink[j]), 64'(exp_f[j]));
    end

    // Backpressure: sink stalls for three cycles mid-packet.
    do_reset();
    src_q[2] = '{mkf(T_HEAD, 'h10), mkf(T_BODY, 'h11), mkf(T_BODY, 'h12), mkf(T_BODY, 'h13),
                 mkf(T_TAIL, 'h14)};
    exp_f = '{mkf(T_HEAD, 'h10), mkf(T_BODY, 'h11), mkf(T_BODY, 'h12), mkf(T_BODY, 'h13),
              mkf(T_TAIL, 'h14)};
    k = 0;
    while (sink.size() < 5 && k < 30) begin
      step(!(k >= 4 && k <= 6));
      if (k >= 4 && k <= 6) begin
        chk($sformatf("bp_out_valid_k%0d", k), 64'(out_valid), 64'(1));
        chk($sformatf("bp_out_flit_k%0d", k), 64'(out_flit), 64'(mkf(T_BODY, 'h12)));
        chk($sformatf("bp_in_ready_k%0d", k), 64'(in_ready), 64'(0));
      end
      k++;
    end
    chk("bp_sink_count", 64'(sink.size()), 64'(5));
    for (int j = 0; j < 5; j++) begin
      if (j < sink.size()) chk($sformatf("bp_flit%0d", j), 64'(sink[j]), 64'(exp_f[j]));
    end

    // Protocol error: HEAD, HEAD, TAIL on port 1; flag sticks once set.
    do_reset();
    src_q[1] = '{mkf(T_HEAD, 'h21), mkf(T_HEAD, 'h22), mkf(T_TAIL, 'h23)};
    for (int c = 0; c < 10; c++) begin
      step(1'b1);
      chk($sformatf("perr_c%0d", c), 64'(proto_err), 64'((3 - src_q[1].size()) >= 2));
    end

    // Async reset after a HEAD on port 2 (pointer is at 2 here).
    src_q[2] = '{mkf(T_HEAD, 'h31), mkf(T_BODY, 'h32), mkf(T_TAIL, 'h33)};
    k = 0;
    while (src_q[2].size() > 2 && k < 10) begin
      step(1'b1);
      k++;
    end
    chk("ar_head_sent", 64'(src_q[2].size()), 64'(2));
    chk("ar_pre_out_valid", 64'(out_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'(0));
    chk("ar_out_flit", 64'(out_flit), 64'(0));
    chk("ar_grant", 64'(grant), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_in_ready", 64'(in_ready), 64'(0));
    chk("ar_proto_err", 64'(proto_err), 64'(0));
    in_valid = '0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    sink.delete();
    last_xfer = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    src_q[0] = '{mkf(T_SGL, 'h400)};
    src_q[2] = '{mkf(T_HEAD, 'h500), mkf(T_TAIL, 'h501)};
    step(1'b1);
    step(1'b1);
    chk("ar_regrant_port0", 64'(grant), 64'(4'b0001));
    k = 0;
    while (sink.size() < 3 && k < 20) begin
      step(1'b1);
      k++;
    end
    chk("ar_sink_count", 64'(sink.size()), 64'(3));
    if (sink.size() > 0) chk("ar_first_out", 64'(sink[0]), 64'(mkf(T_SGL, 'h400)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/flit_link_arbiter.md
# flit_link_arbiter

Round-robin arbiter that shares one network-on-chip link among `NUM_PORTS` packetizer sources. It grants the link for a whole packet, from head flit to tail flit, so flits of different packets never interleave. Each input and the output use a valid/ready handshake. The block sits between the per-core packetizers and the router injection port. It registers the outgoing flit in a one-entry output stage.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting packetizers (2..8).
- `FLIT_DATA_WIDTH`, 32: flit payload width.
- `FLIT_TYPE_WIDTH`, 2: flit type field width, located in the flit MSBs.
- `FLIT_WIDTH`, `FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH`: derived full flit width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  `NUM_PORTS`  per-port flit valid.
- `in_flit`  in  `NUM_PORTS*FLIT_WIDTH`  port i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- `in_ready`  out  `NUM_PORTS`  per-port accept; a flit transfers when `in_valid[i] && in_ready[i]`.
- `out_valid`  out  1  output flit valid.
- `out_flit`  out  `FLIT_WIDTH`  output flit.
- `out_ready`  in  1  link accepts the flit.
- `grant`  out  `NUM_PORTS`  one-hot owner of the link; all zero when idle.
- `busy`  out  1  high in LOCKED.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
Flit types (bits [FLIT_WIDTH-1:FLIT_DATA_WIDTH]):
- 2'b01 HEAD
- 2'b00 BODY
- 2'b10 TAIL
- 2'b11 SINGLE, which is head and tail in one flit.

State machine:
- IDLE
  - Eligible requesters are ports with `in_valid[i]` high and type HEAD or SINGLE.
  - Other valid ports are ignored; their `in_ready` stays 0.
  - If any port is eligible, pick the first eligible port at or after `rr_ptr`, wrapping modulo `NUM_PORTS`.
  - Register `grant` one-hot, set `first`=1, go to LOCKED. `in_ready`=0 in IDLE.
- LOCKED
  - `in_ready[g] = !out_valid || out_ready` for the granted port g; all other `in_ready` bits are 0.
  - On each input transfer, load `out_flit` with the input flit, set `out_valid`, and clear `first`.
  - A transferred HEAD or SINGLE with `first`=0 sets `proto_err`; the flit is still forwarded.
  - A transferred BODY or TAIL with `first`=1 also sets `proto_err`.
  - On transfer of a TAIL or SINGLE flit: clear `grant`, set `rr_ptr = (g+1) mod NUM_PORTS`, go to IDLE.

Output stage:
- `out_valid` clears when `out_ready` is high and no new input transfer occurs that cycle.
- `out_flit` is held stable while `out_valid && !out_ready`.

Boundary conditions:
- Pointer wrap: the port after `NUM_PORTS-1` is 0.
- A granted source deasserting `in_valid` mid-packet keeps the lock. There is no timeout.
- Simultaneous load and drain of the output register in the same cycle is legal, giving full throughput.
- Reset mid-packet: all state cleared and the partial packet is dropped. Sources restart from a HEAD flit.
- `proto_err` clears only on `rst`.

## Timing
- Reset values:
  - `out_valid`=0, `out_flit`=0, `grant`=0, `in_ready`=0, `busy`=0, `proto_err`=0.
  - `rr_ptr`=0, `first`=0, state IDLE.
- Arbitration latency: a request present in IDLE cycle n gives `grant`/`busy` high in cycle n+1.
  - `in_ready[g]` is high in cycle n+1 if the output register is empty or draining.
  - The first flit appears on `out_valid` in cycle n+2.
- Throughput: one flit per cycle while `in_valid[g]` and `out_ready` are both high.
- Inter-packet gap: after the TAIL transfer in cycle m, cycle m+1 is IDLE/arbitration. The next packet's first transfer is no earlier than cycle m+2, a one-bubble minimum.
- `in_ready` is combinational from `out_ready` and registered state. `out_*`, `grant`, `busy` and `proto_err` are registered.

## Test plan
- Single packet: port 2 sends HEAD 0x1, BODY 0x2, TAIL 0x3 with `out_ready`=1 -> `grant`=4'b0100 one cycle after request; `out_flit`={01,1},{00,2},{10,3} on consecutive cycles; `rr_ptr`=3 afterwards; `proto_err`=0.
- Round-robin fairness: all 4 ports continuously offer SINGLE flits from reset -> grants in order 0,1,2,3,0. Each grant is one flit followed by one idle arbitration cycle.
- Packet atomicity: port 0 holds a 4-flit packet while port 1 requests -> port 1 is not granted until the port-0 TAIL transfers, and no port-1 flit appears between port-0 HEAD and TAIL.
- Backpressure: `out_ready`=0 for 3 cycles mid-packet -> `out_flit` is stable, `in_ready[g]`=0 after the register fills, and no flit is lost or duplicated once `out_ready` returns to 1.
- Protocol error: granted port sends HEAD, HEAD -> `proto_err` rises the cycle after the second transfer and stays high until `rst`.
- Asynchronous reset mid-packet: assert `rst` between clock edges after a HEAD -> all outputs reach reset values immediately, without waiting for a clock edge, and a fresh HEAD after release arbitrates from port 0.
